// File: rtl/ws2812b_nrz_decoder.sv
// ws2812b_nrz_decoder: WS2812B single-wire NRZ receiver producing 24-bit GRB words.
//   clk         - system clock
//   reset       - asynchronous active-low reset
//   din         - serial NRZ line, asynchronous to clk
//   pixel_data  - last completed word, first received bit at the MSB
//   pixel_valid - one-cycle strobe, pixel_data is new in that cycle
//   frame_end   - one-cycle strobe when the low latch gap is detected
//   bit_error   - one-cycle strobe on a width violation or a truncated pixel
//   busy        - high while a pulse or the low part of a bit is being timed
module ws2812b_nrz_decoder #(
    parameter int BIT_THRESHOLD_CLK_COUNTS = 30,
    parameter int MIN_HIGH_CLK_COUNTS      = 8,
    parameter int MAX_HIGH_CLK_COUNTS      = 56,
    parameter int RESET_LOW_CLK_COUNTS     = 2500,
    parameter int BITS_PER_PIXEL           = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    output logic [BITS_PER_PIXEL-1:0] pixel_data,
    output logic                      pixel_valid,
    output logic                      frame_end,
    output logic                      bit_error,
    output logic                      busy
);
    localparam int HW = $clog2(MAX_HIGH_CLK_COUNTS + 1) + 1;
    localparam int LW = $clog2(RESET_LOW_CLK_COUNTS) + 1;
    localparam int BW = $clog2(BITS_PER_PIXEL);
    localparam logic [HW-1:0] MIN_W    = HW'(MIN_HIGH_CLK_COUNTS);
    localparam logic [HW-1:0] MAX_W    = HW'(MAX_HIGH_CLK_COUNTS);
    localparam logic [HW-1:0] THR_W    = HW'(BIT_THRESHOLD_CLK_COUNTS);
    localparam logic [LW-1:0] GAP_W    = LW'(RESET_LOW_CLK_COUNTS);
    localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_PIXEL - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, ERROR} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                sync_q, sync_d;
    logic [HW-1:0]             high_cnt_q, high_cnt_d;
    logic [LW-1:0]             low_cnt_q, low_cnt_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
    logic [BITS_PER_PIXEL-1:0] pixel_data_q, pixel_data_d;
    logic                      pixel_valid_q, pixel_valid_d;
    logic                      frame_end_q, frame_end_d;
    logic                      bit_error_q, bit_error_d;
    logic                      din_s, din_p, rise;
    logic [BITS_PER_PIXEL-1:0] next_word;

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect delay
    assign din_s     = sync_q[1];
    assign din_p     = sync_q[2];
    assign rise      = din_s & ~din_p;
    assign next_word = {shift_q[BITS_PER_PIXEL-2:0], high_cnt_q > THR_W};

    always_comb begin
        sync_d        = {sync_q[1:0], din};
        state_d       = state_q;
        high_cnt_d    = high_cnt_q;
        low_cnt_d     = low_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        frame_end_d   = 1'b0;
        bit_error_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d    = HIGH;
                    high_cnt_d = HW'(1);
                end
            end
            HIGH: begin
                // Staying in HIGH means din_s was 1 last cycle, so a 0 here is the falling edge
                if (din_s && high_cnt_q >= MAX_W) begin
                    state_d     = ERROR;
                    high_cnt_d  = MAX_W + 1'b1;
                    low_cnt_d   = '0;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    bit_error_d = 1'b1;
                end else if (din_s) begin
                    high_cnt_d = high_cnt_q + 1'b1;
                end else if (high_cnt_q < MIN_W) begin
                    state_d     = ERROR;
                    low_cnt_d   = '0;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    bit_error_d = 1'b1;
                end else begin
                    state_d   = LOW;
                    low_cnt_d = LW'(1);
                    shift_d   = next_word;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d     = '0;
                        shift_d       = '0;
                        pixel_data_d  = next_word;
                        pixel_valid_d = 1'b1;
                    end
                end
            end
            LOW: begin
                if (din_s) begin
                    state_d    = HIGH;
                    high_cnt_d = HW'(1);
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                    if (low_cnt_d == GAP_W) begin
                        // A latch gap with bits pending means the pixel was truncated
                        state_d     = IDLE;
                        low_cnt_d   = '0;
                        frame_end_d = 1'b1;
                        bit_error_d = bit_cnt_q != '0;
                        bit_cnt_d   = '0;
                        shift_d     = '0;
                    end
                end
            end
            ERROR: begin
                low_cnt_d = din_s ? '0 : low_cnt_q + 1'b1;
                if (low_cnt_d == GAP_W) begin
                    state_d   = IDLE;
                    low_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            frame_end_q   <= 1'b0;
            bit_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            frame_end_q   <= frame_end_d;
            bit_error_q   <= bit_error_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_end   = frame_end_q;
    assign bit_error   = bit_error_q;
    assign busy        = (state_q == HIGH) || (state_q == LOW);
endmodule

// File: tb/tb_ws2812b_nrz_decoder.sv
// tb_ws2812b_nrz_decoder: directed bench for the WS2812B NRZ decoder.
module tb_ws2812b_nrz_decoder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid, frame_end, bit_error, busy;
    int checks = 0, errors = 0, cyc = 0;
    int pv_n = 0, fe_n = 0, be_n = 0;
    int pv_cyc = 0, fe_cyc = 0, be_cyc = 0, last_fall = 0, rise_cyc = 0;
    int p0, f0, b0;
    logic [23:0] pv_data [0:15];
    logic [19:0] tail;
    logic [9:0]  part;

    ws2812b_nrz_decoder dut (
        .clk(clk), .reset(reset), .din(din), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .frame_end(frame_end), .bit_error(bit_error), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pixel_valid) begin
            if (pv_n < 16) pv_data[pv_n] = pixel_data;
            pv_n++;
            pv_cyc = cyc;
        end
        if (frame_end) begin
            fe_n++;
            fe_cyc = cyc;
        end
        if (bit_error) begin
            be_n++;
            be_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input int w);
        din = 1'b1;
        repeat (w) @(negedge clk);
        din = 1'b0;
        last_fall = cyc;
        repeat (62 - w) @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i] ? 40 : 20);
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        gap(3);
        check("rst_data", pixel_data, 0);
        check("rst_valid", pixel_valid, 0);
        check("rst_frame_end", frame_end, 0);
        check("rst_bit_error", bit_error, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        gap(5);
        check("idle_busy", busy, 0);
        send_word(24'h123456);
        gap(5);
        check("t1_count", pv_n, 1);
        check("t1_data", pixel_data, 24'h123456);
        check("t1_latency", pv_cyc - last_fall, 3);
        check("t1_busy", busy, 1);
        gap(2510);
        check("t2_frame_end", fe_n, 1);
        check("t2_fe_latency", fe_cyc - last_fall, 2502);
        check("t2_busy", busy, 0);
        p0 = pv_n;
        send_word(24'hFF0000);
        send_word(24'h00FF00);
        send_word(24'h0000FF);
        gap(2510);
        check("t3_count", pv_n - p0, 3);
        check("t3_pix0", pv_data[p0], 24'hFF0000);
        check("t3_pix1", pv_data[p0+1], 24'h00FF00);
        check("t3_pix2", pv_data[p0+2], 24'h0000FF);
        check("t3_frame_end", fe_n, 2);
        check("t3_no_error", be_n, 0);
        p0 = pv_n;
        tail = 20'h12345;
        send_bit(30);
        send_bit(31);
        send_bit(8);
        send_bit(56);
        for (int i = 19; i >= 0; i--) send_bit(tail[i] ? 40 : 20);
        gap(5);
        check("t4_count", pv_n - p0, 1);
        check("t4_data", pixel_data, 24'h512345);
        check("t4_no_error", be_n, 0);
        b0 = be_n;
        send_bit(5);
        check("t5_glitch_err", be_n - b0, 1);
        check("t5_err_busy", busy, 0);
        p0 = pv_n;
        f0 = fe_n;
        send_word(24'hABCDEF);
        check("t5_ignored", pv_n - p0, 0);
        gap(2510);
        check("t5_no_fe_exit", fe_n - f0, 0);
        send_word(24'hABCDEF);
        gap(5);
        check("t5_recover_cnt", pv_n - p0, 1);
        check("t5_recover_data", pixel_data, 24'hABCDEF);
        check("t5_single_err", be_n - b0, 1);
        gap(2510);
        b0 = be_n;
        p0 = pv_n;
        rise_cyc = cyc;
        din = 1'b1;
        gap(100);
        din = 1'b0;
        gap(10);
        check("t6_stuck_err", be_n - b0, 1);
        check("t6_err_time", be_cyc - rise_cyc, 59);
        check("t6_no_pixel", pv_n - p0, 0);
        check("t6_busy", busy, 0);
        gap(2510);
        f0 = fe_n;
        b0 = be_n;
        part = 10'b1011001110;
        for (int i = 9; i >= 0; i--) send_bit(part[i] ? 40 : 20);
        gap(2510);
        check("t7_frame_end", fe_n - f0, 1);
        check("t7_trunc_err", be_n - b0, 1);
        check("t7_same_cycle", fe_cyc - be_cyc, 0);
        p0 = pv_n;
        send_word(24'h13579B);
        gap(5);
        check("t7_next_cnt", pv_n - p0, 1);
        check("t7_next_data", pixel_data, 24'h13579B);
        gap(2510);
        for (int i = 23; i >= 12; i--) send_bit(i % 2 == 0 ? 40 : 20);
        din = 1'b1;
        gap(10);
        check("t8_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("t8_rst_data", pixel_data, 0);
        check("t8_rst_valid", pixel_valid, 0);
        check("t8_rst_fe", frame_end, 0);
        check("t8_rst_err", bit_error, 0);
        check("t8_rst_busy", busy, 0);
        din = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        gap(5);
        p0 = pv_n;
        b0 = be_n;
        send_word(24'h2468AC);
        gap(5);
        check("t8_after_cnt", pv_n - p0, 1);
        check("t8_after_data", pixel_data, 24'h2468AC);
        check("t8_no_error", be_n - b0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ws2812b_nrz_decoder.md
Name: ws2812b_nrz_decoder

Overview:
- Receive side of the WS2812B single-wire NRZ link; the decoder counterpart to the team's NRZ bit encoder.
- Samples the serial data line and measures the width of each high pulse to classify the bit as code 0 or code 1.
- Assembles 24-bit GRB pixel words, MSB first, and detects the low "reset/latch" gap that ends a frame.
- Used for loop-back verification of the transmit chain and as the input stage of a pass-through (daisy-chain) node.

Parameters:
- BIT_THRESHOLD_CLK_COUNTS, 30, a high width ≤ this value decodes as 0; a width > this value decodes as 1.
- MIN_HIGH_CLK_COUNTS, 8, a high width < this value is a glitch and raises an error.
- MAX_HIGH_CLK_COUNTS, 56, a high width > this value is a stuck-high line and raises an error.
- RESET_LOW_CLK_COUNTS, 2500, continuous low cycles that mark the latch gap (50 us at 50 MHz).
- BITS_PER_PIXEL, 24, number of bits per output word.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- din  in  1  serial NRZ line, asynchronous to clk.
- pixel_data  out  BITS_PER_PIXEL  last completed word; first received bit is at the MSB.
- pixel_valid  out  1  one-cycle strobe; pixel_data is new in that cycle.
- frame_end  out  1  one-cycle strobe when the latch gap is detected.
- bit_error  out  1  one-cycle strobe on a width violation or a truncated pixel.
- busy  out  1  high while in state HIGH or LOW.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, sync flops=0, counters=0, pixel_data=0, pixel_valid=0, frame_end=0, bit_error=0, busy=0.
- Input path: din passes through a 2-flop synchronizer to give din_s, then one more register for edge detection. A din edge is seen by the FSM 3 clk later.
- Width counting: high_cnt counts cycles with din_s=1 and saturates at MAX_HIGH_CLK_COUNTS+1. low_cnt counts cycles with din_s=0 and saturates at RESET_LOW_CLK_COUNTS. Counters are sized with $clog2 of their limit plus 1.
- IDLE:
  - Rising edge → HIGH, high_cnt=1.
  - Low never produces frame_end in IDLE.
- HIGH:
  - Each din_s=1 cycle increments high_cnt.
  - If high_cnt exceeds MAX_HIGH_CLK_COUNTS: pulse bit_error, clear the shift register and bit_cnt, go to ERROR.
  - Falling edge with width < MIN_HIGH_CLK_COUNTS: pulse bit_error, clear shift/bit_cnt, go to ERROR.
  - Falling edge with a valid width: shift in bit = (width > BIT_THRESHOLD_CLK_COUNTS), bit_cnt += 1, low_cnt=1, go to LOW.
  - When bit_cnt wraps from BITS_PER_PIXEL-1 to 0: in the cycle after the falling edge is seen, load pixel_data with the completed word and set pixel_valid=1 for exactly 1 cycle. The shift register then restarts at 0.
- LOW:
  - Rising edge → HIGH (high_cnt=1).
  - If low_cnt reaches RESET_LOW_CLK_COUNTS: pulse frame_end for 1 cycle and go to IDLE.
  - If bit_cnt≠0 at that point, also pulse bit_error in the same cycle and discard the partial bits.
- ERROR:
  - Ignore all pulses.
  - Leave only after RESET_LOW_CLK_COUNTS consecutive low cycles, then go to IDLE.
  - No frame_end is generated on exit.
- Boundaries:
  - Width exactly equal to the threshold decodes as 0.
  - Width exactly MIN or exactly MAX is valid.
  - A glitch shorter than 2 clk may be filtered by the synchronizer; that is not an error.
  - Strobes never overlap except frame_end with bit_error on a truncated pixel.
  - Asynchronous reset mid-word discards all partial state. Stable high at reset release: IDLE waits for a rising edge, so the decoder resynchronises at the next latch.

Test Plan:
- Send 24 bits 0x12_34_56 with high widths 20 (bit 0) and 40 (bit 1), 62-cycle bit period → exactly one pixel_valid, pixel_data=0x123456, 3 cycles after the last falling edge (+1 for the registered output).
- Send 3 pixels (0xFF0000, 0x00FF00, 0x0000FF), then hold low for 2500 cycles → three pixel_valid pulses in order, then one frame_end; bit_error never asserted.
- Send high widths of 30 and 31 → decoded bits 0 and 1. Widths 8 and 56 are accepted. Width 5 → bit_error, state ERROR, and the next pixel_valid only occurs after a 2500-cycle low gap plus a full 24-bit word.
- Hold din high for 100 cycles → bit_error exactly once, at the cycle high_cnt exceeds 56; no pixel_valid.
- Send 10 bits, then low for 2500 cycles → frame_end and bit_error in the same cycle; the following 24-bit word decodes correctly.
- Assert reset in the middle of bit 12 → all outputs 0 immediately; after release, a full frame decodes correctly.
